// File: rtl/rx_cmd_ctrl_pkg.sv
// Shared definitions for the UART receive command sequencer: opcodes,
// FSM state encoding, operand register addresses and the timer width.
package rx_cmd_ctrl_pkg;

    // Command opcodes (first byte of every frame)
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Register-file slots that hold the ALU operands
    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    // Width of the response timeout counter
    localparam int TIMER_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_RD_ADDR  = 4'd3,
        ST_RD_WAIT  = 4'd4,
        ST_OP_A     = 4'd5,
        ST_OP_B     = 4'd6,
        ST_ALU_FUN  = 4'd7,
        ST_ALU_WAIT = 4'd8,
        ST_TX_SEND  = 4'd9
    } state_t;

    // States in which the sequencer waits on a result strobe under timeout
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_RD_WAIT) || (s == ST_ALU_WAIT);
    endfunction

endpackage

// File: rtl/rx_cmd_timeout.sv
// Loadable down-counter guarding the wait for register-read / ALU results.
// expired is high while the count sits at zero.
module rx_cmd_timeout
    import rx_cmd_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   en,
    input  logic [TIMER_WIDTH-1:0] load_val,
    output logic                   expired
);

    logic [TIMER_WIDTH-1:0] count;

    // Count register: load has priority, then decrement while enabled, hold at zero
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: parses opcode frames and drives
// register-file accesses, ALU launches, the ALU clock gate and reply bytes.
// Every output is a flop; the combinational process computes their next values.
module rx_cmd_ctrl
    import rx_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_p_data,
    input  logic                  rx_d_valid,
    input  logic                  rx_err,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    input  logic                  rf_rd_valid,
    output logic                  alu_en,
    output logic [FUN_WIDTH-1:0]  alu_fun,
    output logic                  alu_clk_en,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_out_valid,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_d_valid,
    input  logic                  tx_busy,
    output logic                  cmd_err
);

    state_t state, state_next;

    logic                  rf_wr_en_n, rf_rd_en_n, alu_en_n, alu_clk_en_n;
    logic                  tx_d_valid_n, cmd_err_n;
    logic [ADDR_WIDTH-1:0] rf_addr_n;
    logic [DATA_WIDTH-1:0] rf_wr_data_n, tx_p_data_n;
    logic [FUN_WIDTH-1:0]  alu_fun_n;
    logic                  tmr_load, tmr_en, tmr_expired;

    logic rx_ok, rx_bad;
    assign rx_ok  = rx_d_valid && !rx_err;
    assign rx_bad = rx_d_valid &&  rx_err;

    // The counter is loaded with TIMEOUT-1 so that exactly TIMEOUT wait
    // cycles accept a result; expiry is acted on in the last of them.
    rx_cmd_timeout u_timeout (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (TIMER_WIDTH'(TIMEOUT - 1)),
        .expired  (tmr_expired)
    );

    assign tmr_en = is_wait_state(state);

    // Next-state and next-output decode
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        state_next   = state;
        rf_wr_en_n   = 1'b0;
        rf_rd_en_n   = 1'b0;
        alu_en_n     = 1'b0;
        tx_d_valid_n = 1'b0;
        cmd_err_n    = 1'b0;
        rf_addr_n    = rf_addr;
        rf_wr_data_n = rf_wr_data;
        alu_fun_n    = alu_fun;
        tx_p_data_n  = tx_p_data;

        if (rx_bad) begin
            // A corrupted byte poisons whatever frame is in flight
            cmd_err_n  = 1'b1;
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_ok) begin
                        case (rx_p_data)
                            DATA_WIDTH'(CMD_WR):      state_next = ST_WR_ADDR;
                            DATA_WIDTH'(CMD_RD):      state_next = ST_RD_ADDR;
                            DATA_WIDTH'(CMD_ALU_OP):  state_next = ST_OP_A;
                            DATA_WIDTH'(CMD_ALU_NOP): state_next = ST_ALU_FUN;
                            default:                  cmd_err_n  = 1'b1;
                        endcase
                    end
                end
                ST_WR_ADDR: begin
                    // rf_addr doubles as the latched address until the write strobe
                    if (rx_ok) begin
                        rf_addr_n  = rx_p_data[ADDR_WIDTH-1:0];
                        state_next = ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_ok) begin
                        rf_wr_en_n   = 1'b1;
                        rf_wr_data_n = rx_p_data;
                        state_next   = ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (rx_ok) begin
                        rf_rd_en_n = 1'b1;
                        rf_addr_n  = rx_p_data[ADDR_WIDTH-1:0];
                        state_next = ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // A result arriving on the final timer cycle still wins
                    if (rf_rd_valid) begin
                        tx_p_data_n = rf_rd_data;
                        state_next  = ST_TX_SEND;
                    end else if (tmr_expired) begin
                        cmd_err_n  = 1'b1;
                        state_next = ST_IDLE;
                    end
                    if (rx_ok) cmd_err_n = 1'b1;
                end
                ST_OP_A: begin
                    if (rx_ok) begin
                        rf_wr_en_n   = 1'b1;
                        rf_addr_n    = ADDR_WIDTH'(OPA_ADDR);
                        rf_wr_data_n = rx_p_data;
                        state_next   = ST_OP_B;
                    end
                end
                ST_OP_B: begin
                    if (rx_ok) begin
                        rf_wr_en_n   = 1'b1;
                        rf_addr_n    = ADDR_WIDTH'(OPB_ADDR);
                        rf_wr_data_n = rx_p_data;
                        state_next   = ST_ALU_FUN;
                    end
                end
                ST_ALU_FUN: begin
                    if (rx_ok) begin
                        alu_en_n   = 1'b1;
                        alu_fun_n  = rx_p_data[FUN_WIDTH-1:0];
                        state_next = ST_ALU_WAIT;
                    end
                end
                ST_ALU_WAIT: begin
                    if (alu_out_valid) begin
                        tx_p_data_n = alu_out;
                        state_next  = ST_TX_SEND;
                    end else if (tmr_expired) begin
                        cmd_err_n  = 1'b1;
                        state_next = ST_IDLE;
                    end
                    if (rx_ok) cmd_err_n = 1'b1;
                end
                ST_TX_SEND: begin
                    if (!tx_busy) begin
                        tx_d_valid_n = 1'b1;
                        state_next   = ST_IDLE;
                    end
                    if (rx_ok) cmd_err_n = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end

        // ALU clock runs from ALU_FUN entry until the result (or abort) is seen
        alu_clk_en_n = (state_next == ST_ALU_FUN) || (state_next == ST_ALU_WAIT);

        // Reload the timer only on the transition into a wait state
        tmr_load = is_wait_state(state_next) && (state_next != state);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_addr    <= '0;
            rf_wr_data <= '0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            alu_clk_en <= 1'b0;
            tx_p_data  <= '0;
            tx_d_valid <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_next;
            rf_wr_en   <= rf_wr_en_n;
            rf_rd_en   <= rf_rd_en_n;
            rf_addr    <= rf_addr_n;
            rf_wr_data <= rf_wr_data_n;
            alu_en     <= alu_en_n;
            alu_fun    <= alu_fun_n;
            alu_clk_en <= alu_clk_en_n;
            tx_p_data  <= tx_p_data_n;
            tx_d_valid <= tx_d_valid_n;
            cmd_err    <= cmd_err_n;
        end
    end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed self-checking bench for rx_cmd_ctrl (TIMEOUT set to 8).
module tb_rx_cmd_ctrl;
    import rx_cmd_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_p_data;
    logic       rx_d_valid, rx_err;
    logic       rf_wr_en, rf_rd_en;
    logic [3:0] rf_addr;
    logic [7:0] rf_wr_data, rf_rd_data;
    logic       rf_rd_valid;
    logic       alu_en;
    logic [3:0] alu_fun;
    logic       alu_clk_en;
    logic [7:0] alu_out;
    logic       alu_out_valid;
    logic [7:0] tx_p_data;
    logic       tx_d_valid, tx_busy, cmd_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr = 0, n_rd = 0, n_alu = 0, n_tx = 0, n_err = 0;
    int wr0, rd0, alu0, tx0, err0;

    logic [29:0] all_outs;
    assign all_outs = {rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                       alu_clk_en, tx_p_data, tx_d_valid, cmd_err};

    rx_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_p_data     (rx_p_data),
        .rx_d_valid    (rx_d_valid),
        .rx_err        (rx_err),
        .rf_wr_en      (rf_wr_en),
        .rf_rd_en      (rf_rd_en),
        .rf_addr       (rf_addr),
        .rf_wr_data    (rf_wr_data),
        .rf_rd_data    (rf_rd_data),
        .rf_rd_valid   (rf_rd_valid),
        .alu_en        (alu_en),
        .alu_fun       (alu_fun),
        .alu_clk_en    (alu_clk_en),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .tx_p_data     (tx_p_data),
        .tx_d_valid    (tx_d_valid),
        .tx_busy       (tx_busy),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;

    // Strobe counters, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_wr_en)   n_wr  <= n_wr + 1;
            if (rf_rd_en)   n_rd  <= n_rd + 1;
            if (alu_en)     n_alu <= n_alu + 1;
            if (tx_d_valid) n_tx  <= n_tx + 1;
            if (cmd_err)    n_err <= n_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        rx_p_data  = b;
        rx_d_valid = 1'b1;
        rx_err     = err;
        tick();
        rx_d_valid = 1'b0;
        rx_err     = 1'b0;
    endtask

    task automatic snap();
        wr0 = n_wr; rd0 = n_rd; alu0 = n_alu; tx0 = n_tx; err0 = n_err;
    endtask

    initial begin
        rst = 1'b1; rx_p_data = '0; rx_d_valid = 1'b0; rx_err = 1'b0;
        rf_rd_data = '0; rf_rd_valid = 1'b0; alu_out = '0; alu_out_valid = 1'b0;
        tx_busy = 1'b0;
        tick(); tick();
        check("rst_outs", 32'(all_outs), 32'h0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // Register write: AA 05 3C
        snap();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h05, 1'b0);
        check("wr_no_early_strobe", 32'(rf_wr_en), 32'h0);
        send_byte(8'h3C, 1'b0);
        check("wr_en", 32'(rf_wr_en), 32'h1);
        check("wr_addr", 32'(rf_addr), 32'h5);
        check("wr_data", 32'(rf_wr_data), 32'h3C);
        tick();
        check("wr_en_one_cycle", 32'(rf_wr_en), 32'h0);
        check("wr_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check("wr_no_cmd_err", 32'(n_err - err0), 32'h0);
        check("wr_pulse_count", 32'(n_wr - wr0), 32'h1);

        // Register read: BB 07, overrun byte while waiting, data 0x5A
        snap();
        send_byte(8'hBB, 1'b0);
        send_byte(8'h07, 1'b0);
        check("rd_en", 32'(rf_rd_en), 32'h1);
        check("rd_addr", 32'(rf_addr), 32'h7);
        send_byte(8'h11, 1'b0);
        check("rd_overrun_err", 32'(cmd_err), 32'h1);
        check("rd_overrun_state", 32'(dut.state), 32'(ST_RD_WAIT));
        tick();
        rf_rd_data = 8'h5A; rf_rd_valid = 1'b1;
        tick();
        rf_rd_valid = 1'b0;
        check("rd_tx_not_yet", 32'(tx_d_valid), 32'h0);
        tick();
        check("rd_tx_valid", 32'(tx_d_valid), 32'h1);
        check("rd_tx_data", 32'(tx_p_data), 32'h5A);
        tick();
        check("rd_tx_one_cycle", 32'(tx_d_valid), 32'h0);
        check("rd_pulse_counts", 32'({8'(n_rd - rd0), 8'(n_tx - tx0), 8'(n_err - err0)}), 32'h010101);

        // ALU with operands: CC 10 03 01, result 0x13, transmitter busy for 10 cycles
        snap();
        tx_busy = 1'b1;
        send_byte(8'hCC, 1'b0);
        check("alu_clk_off_opa", 32'(alu_clk_en), 32'h0);
        send_byte(8'h10, 1'b0);
        check("opa_write", 32'({rf_wr_en, rf_addr, rf_wr_data}), {19'h0, 1'b1, 4'h0, 8'h10});
        send_byte(8'h03, 1'b0);
        check("opb_write", 32'({rf_wr_en, rf_addr, rf_wr_data}), {19'h0, 1'b1, 4'h1, 8'h03});
        check("alu_clk_on_fun", 32'(alu_clk_en), 32'h1);
        send_byte(8'h01, 1'b0);
        check("alu_launch", 32'({alu_en, alu_fun, alu_clk_en}), 32'b1_0001_1);
        tick();
        check("alu_en_one_cycle", 32'(alu_en), 32'h0);
        tick(); tick();
        alu_out = 8'h13; alu_out_valid = 1'b1;
        check("alu_clk_at_valid", 32'(alu_clk_en), 32'h1);
        tick();
        alu_out_valid = 1'b0;
        check("alu_clk_off_after", 32'(alu_clk_en), 32'h0);
        repeat (10) tick();
        check("alu_tx_held_busy", 32'(n_tx - tx0), 32'h0);
        tx_busy = 1'b0;
        tick();
        check("alu_tx_valid", 32'(tx_d_valid), 32'h1);
        check("alu_tx_data", 32'(tx_p_data), 32'h13);
        tick();
        check("alu_counts", 32'({8'(n_wr - wr0), 8'(n_alu - alu0), 8'(n_tx - tx0), 8'(n_err - err0)}),
              32'h02010100);

        // Bad opcode, then a frame aborted by a framing error, then a good frame
        snap();
        send_byte(8'h55, 1'b0);
        check("badop_err", 32'(cmd_err), 32'h1);
        tick();
        check("badop_err_one_cycle", 32'(cmd_err), 32'h0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h77, 1'b1);
        check("rxerr_err", 32'(cmd_err), 32'h1);
        check("rxerr_state", 32'(dut.state), 32'(ST_IDLE));
        tick();
        check("rxerr_no_strobes", 32'({8'(n_wr - wr0), 8'(n_rd - rd0), 8'(n_alu - alu0), 8'(n_tx - tx0)}), 32'h0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h44, 1'b0);
        check("recover_write", 32'({rf_wr_en, rf_addr, rf_wr_data}), {19'h0, 1'b1, 4'h3, 8'h44});
        tick();

        // ALU without operands that never answers: timeout after 8 cycles
        snap();
        send_byte(8'hDD, 1'b0);
        check("nop_clk_on", 32'(alu_clk_en), 32'h1);
        send_byte(8'h02, 1'b0);
        check("nop_launch", 32'({alu_en, alu_fun}), 32'b1_0010);
        repeat (7) tick();
        check("to_not_yet", 32'({cmd_err, alu_clk_en}), 32'b01);
        tick();
        check("to_err", 32'({cmd_err, alu_clk_en}), 32'b10);
        check("to_state", 32'(dut.state), 32'(ST_IDLE));
        tick(); tick();
        check("to_no_tx", 32'({8'(n_tx - tx0), 8'(n_err - err0)}), 32'h0001);

        // Read result arriving on the last timer cycle wins over the timeout
        snap();
        send_byte(8'hBB, 1'b0);
        send_byte(8'h04, 1'b0);
        repeat (7) tick();
        rf_rd_data = 8'hA5; rf_rd_valid = 1'b1;
        tick();
        rf_rd_valid = 1'b0;
        check("edge_state", 32'(dut.state), 32'(ST_TX_SEND));
        tick();
        check("edge_tx", 32'({tx_d_valid, tx_p_data}), 32'h1A5);
        tick();
        check("edge_no_err", 32'(n_err - err0), 32'h0);

        // Reset in the middle of an ALU frame
        send_byte(8'hCC, 1'b0);
        send_byte(8'h10, 1'b0);
        rst = 1'b1;
        tick();
        check("midrst_outs", 32'(all_outs), 32'h0);
        check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();
        send_byte(8'hCC, 1'b0);
        send_byte(8'h21, 1'b0);
        check("midrst_new_opa", 32'({rf_wr_en, rf_addr, rf_wr_data}), {19'h0, 1'b1, 4'h0, 8'h21});
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
